wash_cycle_ctrl: RTL and testbench
==================================

// Module: wash_cycle_ctrl
// PURPOSE
//  Cycle sequencer directly downstream of the phase timer. Consumes the timer's
//  phase-done flags (td/tf/tw/tr/ts), drives the actuators (valve, agitator,
//  spin motor, drain pump, door lock) and restarts the timer at every phase change.
//  Sequence: FILL, WASH, DRAIN, then {FILL, RINSE, DRAIN} x RINSES, then SPIN, DONE.
// PARAMETERS
//  RINSES  1  number of rinse passes (1..2**RCW-1)
//  RCW     2  width of the rinse-pass counter
// PORTS
//  clk            in   1  system clock, rising edge
//  reset          in   1  asynchronous, active-high
//  start          in   1  level; request a cycle (sampled in IDLE/DONE only)
//  abort          in   1  level; terminate cycle via drain
//  door_closed    in   1  1 = door shut
//  load_sel       in   3  load size code; latched on start
//  tmr_td/tf/tw/tr/ts in 1 each  timer phase-done flags (levels)
//  tmr_clr        out  1  1-cycle pulse; drives the timer's reset
//  tmr_load       out  3  latched load code; drives the timer's load
//  water_valve    out  1  FILL
//  motor_agit     out  1  WASH, RINSE
//  motor_spin     out  1  SPIN
//  drain_pump     out  1  DRAIN, SPIN
//  door_lock      out  1  any state except IDLE, DONE, HOLD
//  busy           out  1  state != IDLE && state != DONE
//  done           out  1  state == DONE
//  state          out  3  IDLE=0 FILL=1 WASH=2 DRAIN=3 RINSE=4 SPIN=5 DONE=6 HOLD=7
// BEHAVIOUR
//  - All outputs registered. Reset: state=IDLE, every output 0, rinse_cnt=0,
//    washed=0, aborting=0, ret_state=IDLE, armed=0.
//  - Phase entry: on every transition into FILL/WASH/DRAIN/RINSE/SPIN, tmr_clr=1
//    for exactly one cycle and armed=0. armed sets the cycle after tmr_clr drops.
//    Timer flags are ignored while !armed; stale flags from the prior phase never
//    advance the FSM.
//  - Completion flag per phase (only with armed=1): FILL->tf, WASH->tw,
//    DRAIN->td, RINSE->tr, SPIN->ts.
//  - IDLE: start & door_closed -> FILL; latch tmr_load=load_sel; washed=0;
//    rinse_cnt=0. start with door open: stay IDLE.
//  - FILL done: washed ? RINSE : WASH. WASH done: washed=1 -> DRAIN.
//  - DRAIN done: aborting -> IDLE (aborting=0);
//    else rinse_cnt==RINSES -> SPIN; else rinse_cnt++ -> FILL.
//  - RINSE done -> DRAIN. SPIN done -> DONE.
//  - DONE: hold until start==0, then IDLE. start held high never re-runs a cycle.
//  - HOLD: door_closed=0 in FILL/WASH/RINSE/SPIN -> ret_state=current, HOLD;
//    all actuators 0. door_closed=1 -> ret_state (phase re-entry: tmr_clr pulse,
//    phase restarts from count 0). DRAIN ignores the door (pump-only, safe).
//  - abort=1 in FILL/WASH/RINSE/SPIN/HOLD: aborting=1 -> DRAIN (next cycle).
//    abort in IDLE/DONE/DRAIN: ignored (DRAIN already empties).
//  - Priority within one cycle: abort > door open > phase completion.
//  - load_sel changes after start: no effect until next start.
//  - rinse_cnt saturates at RINSES; never wraps.
// TESTING
//  1 Reset mid-WASH: reset=1 -> state=0 and all outputs 0 in the same cycle
//    (async), no tmr_clr pulse.
//  2 Full cycle, RINSES=1, load_sel=1: model timer -> state trace
//    1,2,3,1,4,3,5,6; tmr_clr pulses 7 times; tmr_load=1 throughout.
//  3 Stale flags: hold tf=1 when entering FILL -> FSM stays in FILL >=2 cycles;
//    advances only after tf re-asserts following tmr_clr.
//  4 Door opened in RINSE -> state=7, motor_agit=0, door_lock=0; close ->
//    state=4 with tmr_clr pulse.
//  5 abort in SPIN -> DRAIN (drain_pump=1), then on td -> IDLE, done never
//    asserts.
//  6 start held high through DONE -> stays state=6 until start=0, then
//    state=0; start with door_closed=0 in IDLE -> remains 0.

Source files
------------

// File: rtl/wash_cycle_ctrl.sv
// Wash cycle sequencer. Consumes the phase timer's done flags, drives the
// actuators and door lock, and restarts the timer on every phase entry.
// Sequence: FILL, WASH, DRAIN, {FILL, RINSE, DRAIN} x RINSES, SPIN, DONE.
module wash_cycle_ctrl #(
  parameter int RINSES = 1,
  parameter int RCW    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       door_closed,
  input  logic [2:0] load_sel,
  input  logic       tmr_td,
  input  logic       tmr_tf,
  input  logic       tmr_tw,
  input  logic       tmr_tr,
  input  logic       tmr_ts,
  output logic       tmr_clr,
  output logic [2:0] tmr_load,
  output logic       water_valve,
  output logic       motor_agit,
  output logic       motor_spin,
  output logic       drain_pump,
  output logic       door_lock,
  output logic       busy,
  output logic       done,
  output logic [2:0] state
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FILL  = 3'd1;
  localparam logic [2:0] S_WASH  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_RINSE = 3'd4;
  localparam logic [2:0] S_SPIN  = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;
  localparam logic [2:0] S_HOLD  = 3'd7;

  localparam logic [RCW-1:0] RINSES_C = RCW'(RINSES);

  logic [2:0]     state_q, state_d;
  logic [2:0]     ret_state_q, ret_state_d;
  logic [RCW-1:0] rinse_cnt_q, rinse_cnt_d;
  logic           washed_q, washed_d;
  logic           aborting_q, aborting_d;
  logic           armed_q, armed_d;
  logic [2:0]     tmr_load_q, tmr_load_d;
  logic           tmr_clr_q, tmr_clr_d;
  logic           water_valve_q, water_valve_d;
  logic           motor_agit_q, motor_agit_d;
  logic           motor_spin_q, motor_spin_d;
  logic           drain_pump_q, drain_pump_d;
  logic           door_lock_q, door_lock_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic           phase_flag;
  logic           phase_done;
  logic           entering;

  // States in which the timer is running a timed phase.
  function automatic logic is_phase(input logic [2:0] s);
    return (s == S_FILL) || (s == S_WASH) || (s == S_DRAIN) ||
           (s == S_RINSE) || (s == S_SPIN);
  endfunction

  // Select the completion flag for the current phase; only trusted once armed.
  always_comb begin
    phase_flag = 1'b0;
    case (state_q)
      S_FILL:  phase_flag = tmr_tf;
      S_WASH:  phase_flag = tmr_tw;
      S_DRAIN: phase_flag = tmr_td;
      S_RINSE: phase_flag = tmr_tr;
      S_SPIN:  phase_flag = tmr_ts;
      default: phase_flag = 1'b0;
    endcase
    phase_done = armed_q & phase_flag;
  end

  // Sequencer next-state logic: abort beats door-open beats phase completion.
  always_comb begin
    state_d     = state_q;
    ret_state_d = ret_state_q;
    rinse_cnt_d = rinse_cnt_q;
    washed_d    = washed_q;
    aborting_d  = aborting_q;
    tmr_load_d  = tmr_load_q;
    case (state_q)
      S_IDLE: begin
        if (start && door_closed) begin
          state_d     = S_FILL;
          tmr_load_d  = load_sel;
          washed_d    = 1'b0;
          rinse_cnt_d = '0;
          aborting_d  = 1'b0;
        end
      end
      S_FILL, S_WASH, S_RINSE, S_SPIN: begin
        if (abort) begin
          aborting_d = 1'b1;
          state_d    = S_DRAIN;
        end else if (!door_closed) begin
          ret_state_d = state_q;
          state_d     = S_HOLD;
        end else if (phase_done) begin
          case (state_q)
            S_FILL:  state_d = washed_q ? S_RINSE : S_WASH;
            S_WASH: begin
              washed_d = 1'b1;
              state_d  = S_DRAIN;
            end
            S_RINSE: state_d = S_DRAIN;
            default: state_d = S_DONE;
          endcase
        end
      end
      S_DRAIN: begin
        // The pump-only drain runs regardless of door or abort.
        if (phase_done) begin
          if (aborting_q) begin
            aborting_d = 1'b0;
            state_d    = S_IDLE;
          end else if (rinse_cnt_q >= RINSES_C) begin
            state_d = S_SPIN;
          end else begin
            rinse_cnt_d = rinse_cnt_q + 1'b1;
            state_d     = S_FILL;
          end
        end
      end
      S_DONE: begin
        if (!start) state_d = S_IDLE;
      end
      S_HOLD: begin
        if (abort) begin
          aborting_d = 1'b1;
          state_d    = S_DRAIN;
        end else if (door_closed) begin
          state_d = ret_state_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Timer restart on phase entry and output decode of the upcoming state.
  always_comb begin
    entering      = (state_d != state_q) && is_phase(state_d);
    tmr_clr_d     = entering;
    armed_d       = is_phase(state_d) && !entering && !tmr_clr_q;
    water_valve_d = (state_d == S_FILL);
    motor_agit_d  = (state_d == S_WASH) || (state_d == S_RINSE);
    motor_spin_d  = (state_d == S_SPIN);
    drain_pump_d  = (state_d == S_DRAIN) || (state_d == S_SPIN);
    door_lock_d   = (state_d != S_IDLE) && (state_d != S_DONE) && (state_d != S_HOLD);
    busy_d        = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d        = (state_d == S_DONE);
  end

  // State and registered outputs; reset takes effect immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      ret_state_q   <= S_IDLE;
      rinse_cnt_q   <= '0;
      washed_q      <= 1'b0;
      aborting_q    <= 1'b0;
      armed_q       <= 1'b0;
      tmr_load_q    <= 3'd0;
      tmr_clr_q     <= 1'b0;
      water_valve_q <= 1'b0;
      motor_agit_q  <= 1'b0;
      motor_spin_q  <= 1'b0;
      drain_pump_q  <= 1'b0;
      door_lock_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      ret_state_q   <= ret_state_d;
      rinse_cnt_q   <= rinse_cnt_d;
      washed_q      <= washed_d;
      aborting_q    <= aborting_d;
      armed_q       <= armed_d;
      tmr_load_q    <= tmr_load_d;
      tmr_clr_q     <= tmr_clr_d;
      water_valve_q <= water_valve_d;
      motor_agit_q  <= motor_agit_d;
      motor_spin_q  <= motor_spin_d;
      drain_pump_q  <= drain_pump_d;
      door_lock_q   <= door_lock_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign state       = state_q;
  assign tmr_clr     = tmr_clr_q;
  assign tmr_load    = tmr_load_q;
  assign water_valve = water_valve_q;
  assign motor_agit  = motor_agit_q;
  assign motor_spin  = motor_spin_q;
  assign drain_pump  = drain_pump_q;
  assign door_lock   = door_lock_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_wash_cycle_ctrl.sv
// Directed bench for wash_cycle_ctrl: the bench plays the phase timer by
// raising the matching done flag once the sequencer has had time to arm.
module tb_wash_cycle_ctrl;

  localparam int FL_TD = 0;
  localparam int FL_TF = 1;
  localparam int FL_TW = 2;
  localparam int FL_TR = 3;
  localparam int FL_TS = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       door_closed = 1'b0;
  logic [2:0] load_sel = 3'd0;
  logic [4:0] flags = 5'd0;

  logic       tmr_clr;
  logic [2:0] tmr_load;
  logic       water_valve, motor_agit, motor_spin, drain_pump, door_lock;
  logic       busy, done;
  logic [2:0] state;

  int checks = 0;
  int failures = 0;
  int clr_cnt = 0;
  int done_cnt = 0;
  int snap;

  // Full-cycle phase table: state, its completion flag, expected successor.
  int seq_st[7] = '{1, 2, 3, 1, 4, 3, 5};
  int seq_fl[7] = '{FL_TF, FL_TW, FL_TD, FL_TF, FL_TR, FL_TD, FL_TS};
  int seq_nx[7] = '{2, 3, 1, 4, 3, 5, 6};

  wash_cycle_ctrl #(.RINSES(1), .RCW(2)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .door_closed(door_closed), .load_sel(load_sel),
    .tmr_td(flags[FL_TD]), .tmr_tf(flags[FL_TF]), .tmr_tw(flags[FL_TW]),
    .tmr_tr(flags[FL_TR]), .tmr_ts(flags[FL_TS]),
    .tmr_clr(tmr_clr), .tmr_load(tmr_load),
    .water_valve(water_valve), .motor_agit(motor_agit), .motor_spin(motor_spin),
    .drain_pump(drain_pump), .door_lock(door_lock),
    .busy(busy), .done(done), .state(state)
  );

  always #5 clk = ~clk;

  // Count timer restarts and done cycles away from the active edge.
  always @(negedge clk) begin
    if (tmr_clr === 1'b1) clr_cnt++;
    if (done === 1'b1) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Actuator pattern {valve, agit, spin, pump, lock} expected in each state.
  function automatic logic [7:0] exp_act(input int st);
    case (st)
      1: return 8'b10001;
      2: return 8'b01001;
      3: return 8'b00011;
      4: return 8'b01001;
      5: return 8'b00111;
      default: return 8'b00000;
    endcase
  endfunction

  function automatic logic [7:0] acts();
    return {3'b000, water_valve, motor_agit, motor_spin, drain_pump, door_lock};
  endfunction

  // Called on the first cycle of a phase: checks entry, waits to arm, completes.
  task automatic phase(input int st, input int fl, input int nx);
    chk("phase_state", {5'd0, state}, st[7:0]);
    chk("phase_clr", {7'd0, tmr_clr}, 8'd1);
    chk("phase_act", acts(), exp_act(st));
    tick();
    chk("clr_drop", {7'd0, tmr_clr}, 8'd0);
    tick();
    chk("phase_wait", {5'd0, state}, st[7:0]);
    flags[fl] = 1'b1;
    tick();
    flags[fl] = 1'b0;
    chk("phase_next", {5'd0, state}, nx[7:0]);
    $display("phase %0d -> %0d (state now %0d)", st, nx, state);
  endtask

  initial begin
    // Power-up reset
    tick();
    tick();
    chk("rst_state", {5'd0, state}, 8'd0);
    chk("rst_outs", {tmr_clr, tmr_load, busy, done, 2'b00} | acts(), 8'd0);
    reset = 1'b0;
    tick();

    // Full cycle with load code 1; load_sel change mid-cycle must not matter
    door_closed = 1'b1;
    load_sel = 3'd1;
    start = 1'b1;
    snap = clr_cnt;
    tick();
    start = 1'b0;
    load_sel = 3'd5;
    chk("load_latched", {5'd0, tmr_load}, 8'd1);
    chk("busy_run", {7'd0, busy}, 8'd1);
    for (int i = 0; i < 7; i++) phase(seq_st[i], seq_fl[i], seq_nx[i]);
    chk("done_flag", {6'd0, done, busy}, 8'b10);
    chk("clr_pulses", 8'(clr_cnt - snap), 8'd7);
    chk("load_kept", {5'd0, tmr_load}, 8'd1);
    tick();
    chk("done_to_idle", {5'd0, state}, 8'd0);

    // Reset asserted mid-WASH clears everything without waiting for a clock
    start = 1'b1;
    tick();
    start = 1'b0;
    phase(1, FL_TF, 2);
    #3;
    reset = 1'b1;
    #1;
    chk("async_state", {5'd0, state}, 8'd0);
    chk("async_outs", {tmr_clr, tmr_load, busy, done, 2'b00} | acts(), 8'd0);
    snap = clr_cnt;
    tick();
    reset = 1'b0;
    tick();
    tick();
    chk("no_clr_after_rst", 8'(clr_cnt - snap), 8'd0);
    chk("idle_after_rst", {5'd0, state}, 8'd0);

    // Stale tf held across FILL entry must not advance the sequencer
    flags[FL_TF] = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("stale_entry", {5'd0, state}, 8'd1);
    tick();
    chk("stale_hold1", {5'd0, state}, 8'd1);
    flags[FL_TF] = 1'b0;
    tick();
    chk("stale_hold2", {5'd0, state}, 8'd1);
    tick();
    chk("stale_hold3", {5'd0, state}, 8'd1);
    flags[FL_TF] = 1'b1;
    tick();
    flags[FL_TF] = 1'b0;
    chk("fresh_tf", {5'd0, state}, 8'd2);
    phase(2, FL_TW, 3);
    phase(3, FL_TD, 1);
    phase(1, FL_TF, 4);

    // Door opened during RINSE parks in HOLD; closing re-enters RINSE
    door_closed = 1'b0;
    tick();
    chk("hold_state", {5'd0, state}, 8'd7);
    chk("hold_agit", {6'd0, motor_agit, door_lock}, 8'd0);
    chk("hold_busy", {7'd0, busy}, 8'd1);
    tick();
    chk("hold_stay", {5'd0, state}, 8'd7);
    door_closed = 1'b1;
    tick();
    phase(4, FL_TR, 3);
    phase(3, FL_TD, 5);

    // Abort in SPIN drains and returns to IDLE without DONE
    snap = done_cnt;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_drain", {5'd0, state}, 8'd3);
    chk("abort_pump", {6'd0, drain_pump, motor_spin}, 8'b10);
    phase(3, FL_TD, 0);
    chk("abort_no_done", 8'(done_cnt - snap), 8'd0);

    // start held high through DONE does not re-run the cycle
    start = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) phase(seq_st[i], seq_fl[i], seq_nx[i]);
    tick();
    chk("done_held1", {5'd0, state}, 8'd6);
    tick();
    chk("done_held2", {6'd0, done, door_lock}, 8'b10);
    start = 1'b0;
    tick();
    chk("done_release", {5'd0, state}, 8'd0);
    door_closed = 1'b0;
    start = 1'b1;
    tick();
    tick();
    chk("door_open_start", {5'd0, state}, 8'd0);
    start = 1'b0;

    // Abort wins over a simultaneous door opening; DRAIN ignores the door
    door_closed = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b1;
    door_closed = 1'b0;
    tick();
    abort = 1'b0;
    chk("abort_over_door", {5'd0, state}, 8'd3);
    phase(3, FL_TD, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
